ahb_win_slave: RTL and testbench

Parametrised AHB-Lite slave that sits behind the address filter and answers transfers routed to it. The address is checked against NUM_WIN runtime-programmable windows. Hits are served from an internal word memory with a parametrised number of wait states. Misses, unaligned transfers and oversize transfers get the two-cycle AHB ERROR response. It is the synthesizable responder counterpart to the slave-side bench agent, generalised in width, window count and wait-state timing.

---
 rtl/ahb_win_pkg.sv | 49 ++++
 rtl/ahb_win_decoder.sv | 29 ++
 rtl/ahb_win_slave.sv | 153 +++++++++++++++
 tb/tb_ahb_win_slave.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_win_pkg.sv
// Shared AHB encodings, slave FSM states and byte-lane / size helpers
// for the windowed AHB-Lite slave.
package ahb_win_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam int LANE_MAX = 8;

  // Lanes covered by a 2^size-byte transfer starting at addr_lo within an nbytes-wide word.
  function automatic logic [LANE_MAX-1:0] lane_mask(input logic [2:0] size,
                                                    input logic [2:0] addr_lo,
                                                    input int nbytes);
    int nb;
    int off;
    logic [LANE_MAX-1:0] m;
    nb  = 1 << size;
    off = int'(addr_lo) & (nbytes - 1);
    m   = '0;
    for (int i = 0; i < LANE_MAX; i++)
      if (i >= off && i < off + nb) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic size_legal(input logic [2:0] size,
                                      input logic [2:0] addr_lo,
                                      input int nbytes);
    int nb;
    nb = 1 << size;
    return (nb <= nbytes) && ((int'(addr_lo) & (nb - 1)) == 0);
  endfunction

endpackage

// File: rtl/ahb_win_decoder.sv
// Combinational window match: hit when any enabled window matches under its mask;
// idx_o reports the lowest matching window.
module ahb_win_decoder
  import ahb_win_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_WIN    = 4
) (
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic [NUM_WIN*ADDR_WIDTH-1:0] base_i,
  input  logic [NUM_WIN*ADDR_WIDTH-1:0] mask_i,
  input  logic [NUM_WIN-1:0]            en_i,
  output logic                          hit_o,
  output logic [2:0]                    idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (en_i[i] && ((addr_i & mask_i[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                      (base_i[i*ADDR_WIDTH +: ADDR_WIDTH] & mask_i[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
        hit_o = 1'b1;
        idx_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/ahb_win_slave.sv
// AHB-Lite slave serving NUM_WIN programmable windows from an internal word memory.
// Define AHB_WIN_SLAVE_ERR_EN to enable the two-cycle ERROR response for misses/illegal sizes.
module ahb_win_slave
  import ahb_win_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_WIN     = 4,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic                          hsel,
  input  logic                          hready,
  input  logic [1:0]                    htrans,
  input  logic [2:0]                    hburst,
  input  logic [2:0]                    hsize,
  input  logic                          hwrite,
  input  logic [ADDR_WIDTH-1:0]         haddr,
  input  logic [DATA_WIDTH-1:0]         hwdata,
  input  logic [NUM_WIN*ADDR_WIDTH-1:0] cfg_base,
  input  logic [NUM_WIN*ADDR_WIDTH-1:0] cfg_mask,
  input  logic [NUM_WIN-1:0]            cfg_en,
  output logic                          hreadyout,
  output logic [1:0]                    hresp,
  output logic [DATA_WIDTH-1:0]         hrdata
);

  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NBYTES);
  localparam int IDX_BITS  = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);
`ifdef AHB_WIN_SLAVE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic                  dec_hit;
  logic [2:0]            dec_idx;
  logic                  accept;
  logic                  err;
  logic [IDX_BITS-1:0]   idx;
  logic [LANE_MAX-1:0]   lane_all;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we;
  logic                  unused;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  hreadyout_q;
  hresp_e                hresp_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic                  dp_wr_q;
  logic [IDX_BITS-1:0]   dp_idx_q;
  logic [NBYTES-1:0]     dp_lane_q;

  ahb_win_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WIN    (NUM_WIN)
  ) u_dec (
    .addr_i (haddr),
    .base_i (cfg_base),
    .mask_i (cfg_mask),
    .en_i   (cfg_en),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  // hreadyout_q gates acceptance so nothing is taken while ERR1 or a wait state is showing.
  assign accept   = hsel & hready & hreadyout_q & htrans[1];
  assign err      = ~dec_hit | ~size_legal(hsize, haddr[2:0], NBYTES);
  assign idx      = haddr[LANE_BITS +: IDX_BITS];
  assign lane_all = lane_mask(hsize, haddr[2:0], NBYTES);
  assign mem_we   = dp_wr_q & hreadyout_q & ~hreset;
  assign unused   = ^{hburst, htrans[0], lane_all, dec_idx};

  // A write completing on this edge is forwarded into a read captured on the same edge.
  always_comb begin
    rd_word = mem_q[idx];
    if (mem_we && dp_idx_q == idx)
      for (int b = 0; b < NBYTES; b++)
        if (dp_lane_q[b]) rd_word[8*b +: 8] = hwdata[8*b +: 8];
  end

  always_ff @(posedge hclk) begin
    if (accept) begin
      dp_idx_q  <= idx;
      dp_lane_q <= lane_all[NBYTES-1:0];
    end
    if (mem_we)
      for (int b = 0; b < NBYTES; b++)
        if (dp_lane_q[b]) mem_q[dp_idx_q][8*b +: 8] <= hwdata[8*b +: 8];
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      dp_wr_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == LAST_WAIT) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
`ifdef AHB_WIN_SLAVE_ERR_EN
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
        end
`endif
        default: begin
          state_q     <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
          dp_wr_q     <= 1'b0;
          if (accept) begin
            dp_wr_q <= hwrite & ~err;
            if (!hwrite && !(ERR_ON && err)) hrdata_q <= err ? '0 : rd_word;
            if (WAIT_STATES != 0) begin
              state_q     <= ST_WAIT;
              hreadyout_q <= 1'b0;
              cnt_q       <= '0;
            end
`ifdef AHB_WIN_SLAVE_ERR_EN
            if (err) begin
              state_q     <= ST_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= HRESP_ERROR;
            end
`endif
          end
        end
      endcase
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_win_slave.sv
// Bench for ahb_win_slave: two instances (0 and 3 wait states) share one bus driver
// and are checked cycle by cycle against a transfer-level reference model.
module tb_ahb_win_slave;
  import ahb_win_pkg::*;

  localparam int WS0 = 0;
  localparam int WS1 = 3;
`ifdef AHB_WIN_SLAVE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
  } xfer_t;

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel_b;
  logic        hsel0, hsel1, hready_b;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] cbase [4];
  logic [31:0] cmask [4];
  logic [3:0]  cen;
  logic [127:0] cfg_base, cfg_mask;
  logic        ro0, ro1;
  logic [1:0]  rs0, rs1;
  logic [31:0] rd0, rd1;
  int          cur;
  int          total;
  int          bad;
  logic [31:0] mm [2][64];
  xfer_t       q[$];

  always #5 clk = ~clk;

  assign hsel0    = hsel_b & (cur == 0);
  assign hsel1    = hsel_b & (cur == 1);
  assign hready_b = (cur == 0) ? ro0 : ro1;
  assign cfg_base = {cbase[3], cbase[2], cbase[1], cbase[0]};
  assign cfg_mask = {cmask[3], cmask[2], cmask[1], cmask[0]};

  ahb_win_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WIN(4), .MEM_DEPTH(64), .WAIT_STATES(WS0)) u0 (
    .hclk(clk), .hreset(hreset), .hsel(hsel0), .hready(hready_b), .htrans(htrans),
    .hburst(hburst), .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_en(cen),
    .hreadyout(ro0), .hresp(rs0), .hrdata(rd0));

  ahb_win_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WIN(4), .MEM_DEPTH(64), .WAIT_STATES(WS1)) u1 (
    .hclk(clk), .hreset(hreset), .hsel(hsel1), .hready(hready_b), .htrans(htrans),
    .hburst(hburst), .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_en(cen),
    .hreadyout(ro1), .hresp(rs1), .hrdata(rd1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input xfer_t x);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (cen[i] && ((x.addr & cmask[i]) == (cbase[i] & cmask[i]))) hit = 1'b1;
    return !hit || (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0);
  endfunction

  function automatic void mwrite(input xfer_t x);
    int off;
    int nb;
    off = int'(x.addr[1:0]);
    nb  = 1 << x.size;
    for (int b = off; b < off + nb; b++)
      mm[cur][x.addr[7:2]][8*b +: 8] = x.wdata[8*b +: 8];
  endfunction

  task automatic enq(input logic [31:0] a, input logic w, input logic [2:0] s,
                     input logic [31:0] d, input logic [1:0] t);
    xfer_t x;
    x.addr = a; x.wr = w; x.size = s; x.wdata = d; x.trans = t;
    q.push_back(x);
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic run(input int maxc);
    xfer_t       dp;
    logic        dp_v, dp_err, rdy;
    int          dpc, cyc, ws;
    logic [1:0]  rsp;
    logic [31:0] rdv;
    dp_v = 1'b0; dp_err = 1'b0; dpc = 0; cyc = 0;
    ws = (cur == 0) ? WS0 : WS1;
    while ((q.size() > 0 || dp_v) && cyc < maxc) begin
      rdy = (cur == 0) ? ro0 : ro1;
      rsp = (cur == 0) ? rs0 : rs1;
      rdv = (cur == 0) ? rd0 : rd1;
      if (dp_v && dp_err && ERR_ON) begin
        chk("err_ready", rdy, dpc == 1);
        chk("err_resp", rsp, 2'b01);
      end else if (dp_v) begin
        chk("hit_ready", rdy, dpc == ws);
        chk("hit_resp", rsp, 2'b00);
        if (dpc == ws && !dp.wr)
          chk("rdata", rdv, dp_err ? 32'd0 : mm[cur][dp.addr[7:2]]);
      end else begin
        chk("idle_ready", rdy, 1);
        chk("idle_resp", rsp, 2'b00);
      end
      hwdata = dp_v ? dp.wdata : $urandom;
      if (q.size() > 0) begin
        hsel_b = 1'b1; htrans = q[0].trans; haddr = q[0].addr;
        hwrite = q[0].wr; hsize = q[0].size;
      end else begin
        hsel_b = 1'b0; htrans = HTRANS_IDLE; haddr = $urandom;
        hwrite = 1'b0; hsize = 3'd0;
      end
      @(posedge clk); #1;
      cyc++;
      if (rdy === 1'b1) begin
        if (dp_v && dp.wr && !dp_err) mwrite(dp);
        dp_v = 1'b0;
        if (q.size() > 0) begin
          if (q[0].trans[1]) begin
            dp = q[0]; dp_v = 1'b1; dpc = 0; dp_err = is_err(dp);
          end
          void'(q.pop_front());
        end
      end else begin
        dpc++;
      end
    end
    hsel_b = 1'b0; htrans = HTRANS_IDLE;
    chk("timeout", cyc < maxc, 1);
    q.delete();
  endtask

  task automatic init_mem();
    for (int i = 0; i < 64; i++)
      enq(32'h1000_0000 + 32'(4 * i), 1'b1, 3'd2, $urandom, HTRANS_NONSEQ);
    run(64 * 8);
  endtask

  task automatic rand_mix(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      case ($urandom_range(0, 7))
        0, 1, 2: a = 32'h1000_0000;
        3, 4:    a = 32'h1100_0000;
        5:       a = 32'h1234_0000;
        6:       a = 32'h3000_0000;
        default: a = 32'h2000_0000;
      endcase
      a  = a | 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 5) == 0)
        enq($urandom, 1'b0, 3'd2, 32'd0, 2'($urandom_range(0, 1)));
      enq(a, 1'($urandom_range(0, 1)), sz, $urandom, HTRANS_NONSEQ);
    end
    run(n * 20);
  endtask

  initial begin
    logic [31:0] old;
    total = 0; bad = 0; cur = 0;
    cbase[0] = 32'h1000_0000; cmask[0] = 32'hFFFF_0000;
    cbase[1] = 32'h1100_0000; cmask[1] = 32'hFF00_0000;
    cbase[2] = 32'h3000_0000; cmask[2] = 32'hF000_0000;
    cbase[3] = 32'h1234_0000; cmask[3] = 32'hFFFF_0000;
    cen = 4'b1011;
    hreset = 1'b1; hsel_b = 1'b0; htrans = HTRANS_IDLE; hburst = 3'b011;
    hsize = 3'd0; hwrite = 1'b0; haddr = '0; hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", ro0, 1); chk("rst_resp0", rs0, 0); chk("rst_rdata0", rd0, 0);
    chk("rst_ready1", ro1, 1); chk("rst_resp1", rs1, 0); chk("rst_rdata1", rd1, 0);
    hreset = 1'b0;
    @(posedge clk); #1;

    // zero-wait instance
    cur = 0;
    init_mem();
    enq(32'h1000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF, HTRANS_NONSEQ);
    enq(32'h1000_0010, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    run(20);
    chk("deadbeef", rd0, 32'hDEAD_BEEF);
    enq(32'h2000_0000, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    enq(32'h3000_0004, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    enq(32'h1000_0008, 1'b0, 3'd3, 32'h0, HTRANS_NONSEQ);
    run(30);
    old = mm[0][0];
    enq(32'h1000_0002, 1'b1, 3'd2, 32'h5555_AAAA, HTRANS_NONSEQ);
    enq(32'h1000_0000, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    run(20);
    chk("unaligned_old", rd0, old);
    enq(32'h1000_00FC, 1'b1, 3'd2, $urandom, HTRANS_NONSEQ);
    enq(32'h1000_0100, 1'b1, 3'd2, $urandom, HTRANS_SEQ);
    enq(32'h1000_0104, 1'b1, 3'd2, $urandom, HTRANS_SEQ);
    enq(32'h1000_0108, 1'b1, 3'd2, $urandom, HTRANS_SEQ);
    enq(32'h1000_00FC, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    enq(32'h1000_0100, 1'b0, 3'd2, 32'h0, HTRANS_SEQ);
    enq(32'h1000_0000, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    enq(32'h1000_0108, 1'b0, 3'd2, 32'h0, HTRANS_SEQ);
    run(30);
    rand_mix(150);

    // three-wait instance
    cur = 1;
    init_mem();
    enq(32'h1000_0010, 1'b1, 3'd2, 32'h1122_3344, HTRANS_NONSEQ);
    enq(32'h1000_0013, 1'b1, 3'd0, 32'hAB00_0000, HTRANS_NONSEQ);
    enq(32'h1000_0010, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    run(30);
    chk("byte_merge", rd1, 32'hAB22_3344);
    enq(32'h2000_0000, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    enq(32'h1000_0006, 1'b1, 3'd1, 32'h7777_7777, HTRANS_NONSEQ);
    enq(32'h1000_0006, 1'b1, 3'd2, 32'h7777_7777, HTRANS_NONSEQ);
    enq(32'h1000_0004, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    run(40);
    rand_mix(80);

    // reset lands in the middle of a write's wait states
    old = mm[1][8];
    hsel_b = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h1000_0020;
    hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel_b = 1'b0; htrans = HTRANS_IDLE; hwdata = ~old;
    chk("wait_ready_low", ro1, 0);
    @(posedge clk); #1;
    hreset = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b0;
    chk("midrst_ready", ro1, 1); chk("midrst_resp", rs1, 0); chk("midrst_rdata", rd1, 0);
    enq(32'h1000_0020, 1'b0, 3'd2, 32'h0, HTRANS_NONSEQ);
    run(20);
    chk("midrst_word", rd1, old);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
